// File: rtl/tick_scheduler_pkg.sv
// Shared constants and encodings for the PLL-following tick scheduler.
// Holds the FSM states, the reset defaults and the config-kind codes.
package tick_scheduler_pkg;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    localparam int          TICK_WIDTH          = 27;
    localparam int unsigned TICK_DEFAULT_PERIOD = 124500000;
    localparam int          TICK_MIN_LEN        = 2;

    localparam logic CFG_PERIOD = 1'b0;
    localparam logic CFG_PHASE  = 1'b1;

endpackage

// File: rtl/tick_scheduler_if.sv
// Host-side configuration port: valid/ready handshake carrying a kind bit and a data word.
// The host drives the master modport, the scheduler consumes the slave modport.
interface tick_scheduler_if #(
    parameter int WIDTH = 27
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_kind;
    logic [WIDTH-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_kind,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_kind,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/tick_scheduler_sync2.sv
// Two-flop synchroniser for a single level signal coming from another clock domain.
// Output is the input delayed by two clk edges; both flops clear on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/tick_scheduler.sv
// Periodic tick generator gated by PLL lock, with period/phase updates that only take
// effect at a period boundary so no tick is ever glitched or duplicated.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int          WIDTH          = TICK_WIDTH,
    parameter int unsigned DEFAULT_PERIOD = TICK_DEFAULT_PERIOD,
    parameter int          MIN_LEN        = TICK_MIN_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    tick_scheduler_if.slave  cfg,
    output logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic             half,
    output logic             pending
);
    // Two guard bits keep the phase sum from wrapping before it is saturated.
    localparam int SW = WIDTH + 2;

    localparam logic [WIDTH-1:0]     DEF_LEN = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0]     MIN_VAL = WIDTH'(MIN_LEN);
    localparam logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}};
    localparam logic signed [SW-1:0] MIN_SUM = SW'(MIN_LEN);
    localparam logic signed [SW-1:0] MAX_SUM = {2'b00, MAX_VAL};

    state_t           state_reg,     state_next;
    logic [WIDTH-1:0] cnt_reg,       cnt_next;
    logic [WIDTH-1:0] cur_len_reg,   cur_len_next;
    logic [WIDTH-1:0] period_reg,    period_next;
    logic             pending_reg,   pending_next;
    logic             kind_reg,      kind_next;
    logic [WIDTH-1:0] data_reg,      data_next;
    logic             cfg_ready_reg, cfg_ready_next;

    logic                 locked_s;
    logic                 accept;
    logic                 wrap;
    logic [WIDTH-1:0]     in_period_len;
    logic [WIDTH-1:0]     shadow_period_len;
    logic signed [SW-1:0] phase_sum;
    logic [WIDTH-1:0]     phase_len;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    assign accept = cfg.cfg_valid && cfg_ready_reg;
    // Compare with >= so a shortened cur_len can never strand cnt above it.
    assign wrap   = (state_reg == RUN) && (cnt_reg >= cur_len_reg - 1'b1);

    assign in_period_len     = (cfg.cfg_data < MIN_VAL) ? MIN_VAL : cfg.cfg_data;
    assign shadow_period_len = (data_reg < MIN_VAL) ? MIN_VAL : data_reg;

    assign phase_sum = $signed({2'b00, period_reg})
                     + $signed({{2{data_reg[WIDTH-1]}}, data_reg});

    always_comb begin
        phase_len = phase_sum[WIDTH-1:0];
        if (phase_sum < MIN_SUM) begin
            phase_len = MIN_VAL;
        end else if (phase_sum > MAX_SUM) begin
            phase_len = MAX_VAL;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cur_len_next = cur_len_reg;
        period_next  = period_reg;
        pending_next = pending_reg;
        kind_next    = kind_reg;
        data_next    = data_reg;

        case (state_reg)
            WAIT_LOCK: begin
                cnt_next = '0;
                // While idle a period write takes effect at once; phase steps are dropped
                // and any shadow carried over from RUN is left untouched.
                if (accept && (cfg.cfg_kind == CFG_PERIOD)) begin
                    period_next  = in_period_len;
                    cur_len_next = in_period_len;
                end
                if (locked_s) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (wrap) begin
                    cnt_next = '0;
                    if (pending_reg) begin
                        pending_next = 1'b0;
                        if (kind_reg == CFG_PERIOD) begin
                            period_next  = shadow_period_len;
                            cur_len_next = shadow_period_len;
                        end else begin
                            cur_len_next = phase_len;
                        end
                    end else begin
                        cur_len_next = period_reg;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end

                // Accepts only happen with pending clear, so this never races the wrap above.
                if (accept) begin
                    pending_next = 1'b1;
                    kind_next    = cfg.cfg_kind;
                    data_next    = cfg.cfg_data;
                end
            end

            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase

        cfg_ready_next = (state_next == WAIT_LOCK) ? 1'b1 : !pending_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= WAIT_LOCK;
            cnt_reg       <= '0;
            cur_len_reg   <= DEF_LEN;
            period_reg    <= DEF_LEN;
            pending_reg   <= 1'b0;
            kind_reg      <= CFG_PERIOD;
            data_reg      <= '0;
            cfg_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cur_len_reg   <= cur_len_next;
            period_reg    <= period_next;
            pending_reg   <= pending_next;
            kind_reg      <= kind_next;
            data_reg      <= data_next;
            cfg_ready_reg <= cfg_ready_next;
        end
    end

    assign tick          = (state_reg == RUN) && (cnt_reg == '0);
    assign cnt           = cnt_reg;
    assign half          = cnt_reg > (cur_len_reg >> 1);
    assign pending       = pending_reg;
    assign cfg.cfg_ready = cfg_ready_reg;
endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler at WIDTH=8, DEFAULT_PERIOD=10, MIN_LEN=2.
// Expected tick-to-tick intervals are queued with each stimulus and popped on every tick.
`timescale 1ns/1ps
module tb_tick_scheduler;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         locked;
    logic         tick;
    logic [W-1:0] cnt;
    logic         half;
    logic         pending;

    tick_scheduler_if #(.WIDTH(W)) cfg_if ();

    tick_scheduler #(
        .WIDTH          (W),
        .DEFAULT_PERIOD (10),
        .MIN_LEN        (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .locked  (locked),
        .cfg     (cfg_if),
        .tick    (tick),
        .cnt     (cnt),
        .half    (half),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int cyc       = 0;
    int last_tick = 0;
    bit have_last = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Tick monitor: samples 2 ns after each rising edge, pops one expected interval per tick.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (tick) begin
            check("tick_cnt_zero", int'(cnt), 0);
            if (have_last && exp_q.size() > 0) begin
                check("period", cyc - last_tick, exp_q.pop_front());
            end
            last_tick = cyc;
            have_last = 1'b1;
        end
    end

    task automatic send_cfg(input logic kind, input logic [W-1:0] data, output int stall);
        int acc_cnt;
        stall = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_kind  = kind;
        cfg_if.cfg_data  = data;
        while (!cfg_if.cfg_ready && stall < 300) begin
            @(negedge clk);
            stall++;
        end
        if (!cfg_if.cfg_ready) check("cfg_accept_timeout", 0, 1);
        acc_cnt = int'(cnt);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        $display("cfg kind=%0d data=%0d accepted at cnt=%0d after %0d stall cycles",
                 kind, data, acc_cnt, stall);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 300);
        if (!tick) check("tick_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(cnt) != v && n < 300);
        check("wait_cnt_reached", int'(cnt), v);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int n;
        rst_n = 1'b0;
        locked = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_kind  = 1'b0;
        cfg_if.cfg_data  = '0;

        // 1: reset state, lock latency, epoch tick, half window
        repeat (3) @(negedge clk);
        check("rst_tick", int'(tick), 0);
        check("rst_cnt", int'(cnt), 0);
        check("rst_half", int'(half), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_ready", int'(cfg_if.cfg_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("wait_lock_ready", int'(cfg_if.cfg_ready), 1);
        check("wait_lock_tick1", int'(tick), 0);
        @(negedge clk);
        check("wait_lock_tick2", int'(tick), 0);
        @(negedge clk);
        check("epoch_tick", int'(tick), 1);
        exp_q.push_back(10);
        exp_q.push_back(10);
        for (int k = 0; k < 10; k++) begin
            check("p1_cnt", int'(cnt), k);
            check("p1_half", int'(half), (k >= 6) ? 1 : 0);
            check("p1_tick", int'(tick), (k == 0) ? 1 : 0);
            @(negedge clk);
        end
        drain();

        // 2: period write 5 mid-period
        wait_cnt(3);
        exp_q.push_back(10);
        exp_q.push_back(5);
        exp_q.push_back(5);
        send_cfg(1'b0, 8'd5, st);
        check("p2_pending_set", int'(pending), 1);
        check("p2_ready_low", int'(cfg_if.cfg_ready), 0);
        wait_tick(n);
        check("p2_pending_clr", int'(pending), 0);
        check("p2_ready_high", int'(cfg_if.cfg_ready), 1);
        drain();

        // 3: back to 10, then phase +3 and phase -20 (clamped to 2)
        exp_q.push_back(5);
        exp_q.push_back(10);
        send_cfg(1'b0, 8'd10, st);
        drain();
        exp_q.push_back(10);
        exp_q.push_back(13);
        exp_q.push_back(10);
        send_cfg(1'b1, 8'd3, st);
        drain();
        exp_q.push_back(10);
        exp_q.push_back(2);
        exp_q.push_back(10);
        send_cfg(1'b1, 8'hEC, st);
        drain();

        // 4: back-to-back requests, second stalls until the wrap
        exp_q.push_back(10);
        exp_q.push_back(6);
        exp_q.push_back(8);
        exp_q.push_back(6);
        send_cfg(1'b0, 8'd6, st);
        check("p4_first_stall", st, 0);
        send_cfg(1'b1, 8'd2, st);
        check("p4_second_stall", st, 9);
        check("p4_second_pending", int'(pending), 1);
        drain();
        exp_q.push_back(6);
        exp_q.push_back(10);
        send_cfg(1'b0, 8'd10, st);
        drain();
        // accept on cnt=9 is deferred by one whole period
        wait_cnt(9);
        exp_q.push_back(10);
        exp_q.push_back(10);
        exp_q.push_back(11);
        exp_q.push_back(10);
        send_cfg(1'b1, 8'd1, st);
        check("p4_defer_tick", int'(tick), 1);
        check("p4_defer_pending", int'(pending), 1);
        check("p4_defer_ready", int'(cfg_if.cfg_ready), 0);
        drain();

        // 5: lose lock with a phase step pending, idle writes, relock
        send_cfg(1'b1, 8'd4, st);
        wait_cnt(4);
        locked = 1'b0;
        @(negedge clk);
        check("p5_cnt5", int'(cnt), 5);
        @(negedge clk);
        check("p5_cnt6", int'(cnt), 6);
        @(negedge clk);
        check("p5_idle_cnt", int'(cnt), 0);
        check("p5_idle_tick", int'(tick), 0);
        check("p5_idle_ready", int'(cfg_if.cfg_ready), 1);
        check("p5_idle_pending", int'(pending), 1);
        send_cfg(1'b1, 8'd50, st);
        send_cfg(1'b0, 8'd1, st);
        check("p5_idle_tick2", int'(tick), 0);
        check("p5_kept_pending", int'(pending), 1);
        locked = 1'b1;
        wait_tick(n);
        check("p5_relock_latency", n, 3);
        check("p5_epoch_cnt", int'(cnt), 0);
        check("p5_epoch_pending", int'(pending), 1);
        check("p5_epoch_ready", int'(cfg_if.cfg_ready), 0);
        exp_q.push_back(2);
        exp_q.push_back(6);
        exp_q.push_back(2);
        drain();

        // 6: async reset mid-period with a step pending
        exp_q.push_back(2);
        exp_q.push_back(9);
        send_cfg(1'b0, 8'd9, st);
        drain();
        send_cfg(1'b1, 8'd2, st);
        wait_cnt(7);
        check("p6_pre_pending", int'(pending), 1);
        check("p6_pre_half", int'(half), 1);
        rst_n = 1'b0;
        #1;
        check("p6_rst_tick", int'(tick), 0);
        check("p6_rst_cnt", int'(cnt), 0);
        check("p6_rst_half", int'(half), 0);
        check("p6_rst_pending", int'(pending), 0);
        check("p6_rst_ready", int'(cfg_if.cfg_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        check("p6_lock_latency", n, 3);
        exp_q.push_back(10);
        exp_q.push_back(10);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
